// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - job, operand, slice and result signal bundle for dsp_mac_sequencer
//
// Purpose: groups every non-clock/reset signal of dsp_mac_sequencer.
// Ports (modport slave = sequencer side, master = environment side):
//   start, len                  job command, sampled in IDLE
//   in_valid, in_ready, in_a/b  operand pair stream
//   dsp_a, dsp_b, dsp_opmode,   registered operands, opmode and clock enable
//   dsp_ce, dsp_p                 to the slice; slice P back to the sequencer
//   busy                        high outside IDLE
//   out_valid, out_ready,       held dot-product result handshake
//   result
interface dsp_mac_sequencer_if #(
  parameter int datainwidth  = 18,
  parameter int dataoutwidth = 48,
  parameter int lenwidth     = 16
);
  logic                    start;
  logic [lenwidth-1:0]     len;
  logic                    in_valid;
  logic                    in_ready;
  logic [datainwidth-1:0]  in_a;
  logic [datainwidth-1:0]  in_b;
  logic [datainwidth-1:0]  dsp_a;
  logic [datainwidth-1:0]  dsp_b;
  logic [7:0]              dsp_opmode;
  logic                    dsp_ce;
  logic [dataoutwidth-1:0] dsp_p;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [dataoutwidth-1:0] result;

  modport slave (
    input  start, len, in_valid, in_a, in_b, dsp_p, out_ready,
    output in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, busy, out_valid, result
  );

  modport master (
    output start, len, in_valid, in_a, in_b, dsp_p, out_ready,
    input  in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, busy, out_valid, result
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - dot-product job sequencer driving one pipelined DSP slice
//
// Purpose: accepts a job (start/len), streams len operand pairs into the slice
// while generating a clear-then-accumulate opmode, and captures the final P as
// a held result behind a valid/ready handshake.
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset; aborts any job in flight
//   bus (slave)  job command, operand stream, slice connection, busy, result
module dsp_mac_sequencer #(
  parameter int datainwidth  = 18,
  parameter int dataoutwidth = 48,
  parameter int lenwidth     = 16,
  parameter int OPLAG        = 1,
  parameter int PLAT         = 3
) (
  input  logic               clk,
  input  logic               rstn,
  dsp_mac_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] OPM_IDLE  = 8'h00;
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0: clears the previous job's P
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P: bubble, P holds
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P

  typedef struct packed {
    logic live;   // pushed during this job; cleared entries give the idle opmode
    logic v;
    logic first;
    logic last;
  } tag_t;

  localparam int TAGW = (PLAT + 1) * $bits(tag_t);

  logic [1:0]              state_q, state_d;
  logic [lenwidth-1:0]     remaining_q, remaining_d;
  logic                    first_q, first_d;
  // Entry k describes the operand issued k cycles ago; entry 0 is the issue cycle.
  tag_t [PLAT:0]           tag_q, tag_d;
  logic [datainwidth-1:0]  dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d;
  logic [7:0]              opmode_q, opmode_d;
  logic                    out_valid_q, out_valid_d;
  logic [dataoutwidth-1:0] result_q, result_d;

  logic pipe_en, hs_in, hs_out, last_pair, done_tag;
  tag_t tag_in, tag_op;

  assign pipe_en   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign hs_in     = (state_q == S_RUN) && bus.in_valid;
  assign hs_out    = out_valid_q && bus.out_ready;
  assign last_pair = (remaining_q == lenwidth'(1));
  assign tag_in    = '{live: 1'b1, v: hs_in, first: hs_in & first_q, last: hs_in & last_pair};
  // The opmode register adds one cycle, so it is fed from the tap one short of OPLAG.
  assign tag_op    = tag_q[OPLAG-1];
  assign done_tag  = tag_q[PLAT].live & tag_q[PLAT].v & tag_q[PLAT].last;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    tag_d       = tag_q;
    dsp_a_d     = dsp_a_q;
    dsp_b_d     = dsp_b_q;
    opmode_d    = OPM_IDLE;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    if (pipe_en) begin
      tag_d = TAGW'({tag_q, tag_in});
      if (tag_op.live) begin
        if (!tag_op.v)         opmode_d = OPM_HOLD;
        else if (tag_op.first) opmode_d = OPM_FIRST;
        else                   opmode_d = OPM_ACC;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tag_d   = '0;
          first_d = 1'b1;
          if (bus.len == '0) begin
            result_d    = '0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            remaining_d = bus.len;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (hs_in) begin
          dsp_a_d     = bus.in_a;
          dsp_b_d     = bus.in_b;
          first_d     = 1'b0;
          remaining_d = remaining_q - lenwidth'(1);
          if (last_pair) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done_tag) begin
          result_d    = bus.dsp_p;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here, even on the handshake cycle.
        if (hs_out) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      tag_q       <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      opmode_q    <= OPM_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      tag_q       <= tag_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
      opmode_q    <= opmode_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign bus.in_ready   = (state_q == S_RUN);
  assign bus.dsp_ce     = pipe_en;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.dsp_a      = dsp_a_q;
  assign bus.dsp_b      = dsp_b_q;
  assign bus.dsp_opmode = opmode_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
Controller that runs N-term multiply-accumulate (dot-product) jobs on one dsptop slice instance. It accepts a job command and then a valid/ready stream of (a,b) operand pairs. It issues the operands to the slice and generates a per-cycle opmode that clears and then accumulates P. It captures the final P into a held result with a valid/ready output handshake. It sits between a sample source (FIR/correlator front end) and the DSP slice; a top-level wrapper instantiates both.

Parameters:
datainwidth, 18, operand width (matches slice A/B)
dataoutwidth, 48, P/result width
lenwidth, 16, job length counter width
OPLAG, 1, cycles from operand issue to opmode driven at slice (slice built with A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0)
PLAT, 3, cycles from operand issue to P valid at slice output

Ports:
clk  in  1  clock; all registers on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled only in IDLE
len  in  lenwidth  number of operand pairs in the job; sampled with start
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted when in_valid&in_ready
in_a  in  datainwidth  multiplicand
in_b  in  datainwidth  multiplier
dsp_a  out  datainwidth  to slice a (registered)
dsp_b  out  datainwidth  to slice b (registered)
dsp_opmode  out  8  to slice opmode (registered)
dsp_ce  out  1  drives slice cea/ceb/cem/cep/ceopmode
dsp_p  in  dataoutwidth  slice p output
busy  out  1  high in every state except IDLE
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
result  out  dataoutwidth  accumulated dot product

Behaviour:
- Reset (async, rstn=0): state=IDLE; all outputs 0; tag pipe and counters cleared. Reset mid-job aborts the job with no result.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0, dsp_ce=0. On start: if len=0, result<=0 and go to DONE; otherwise load remaining<=len and go to RUN. start outside IDLE is ignored.
- RUN: in_ready=1. On handshake, register in_a/in_b onto dsp_a/dsp_b next cycle (issue cycle). Push tag {v=1, first=(first accepted pair), last=(remaining==1)} and decrement remaining. Without a handshake, push a bubble tag {v=0}; dsp_a/dsp_b hold. The last handshake moves to DRAIN.
- dsp_ce=1 in RUN and DRAIN.
- Tag pipe: PLAT-deep shift register advancing every cycle in RUN/DRAIN.
- Opmode generation at tap OPLAG:
  - v&first gives 0x01 (X=M, Z=0, add, cin=0, preadder bypass).
  - v&!first gives 0x09 (X=M, Z=P).
  - bubble gives 0x08 (X=0, Z=P; P holds).
  - Default/idle opmode is 0x00.
- DRAIN: in_ready=0. When the tag with last=1 reaches tap PLAT, result<=dsp_p, out_valid<=1, go to DONE.
- DONE: out_valid=1; result is stable until out_valid&out_ready. On that handshake, out_valid<=0 and go to IDLE; a new start is accepted the following cycle. Simultaneous start and output handshake in DONE: start is ignored.
- Job latency: from last operand handshake to out_valid is PLAT+1 cycles.
- Arithmetic: accumulation wraps modulo 2^dataoutwidth inside the slice. The block does no overflow detection.

Test Plan:
- len=4, a=1,2,3,4, b=2 every cycle -> dsp_opmode sequence 0x01,0x09,0x09,0x09; result=20, out_valid 4 cycles after last handshake.
- Same job with in_valid low for 2 cycles between pairs 2 and 3 -> two 0x08 opmodes inserted, result still 20.
- len=0 start -> out_valid=1 with result=0 next cycle, no dsp_ce pulse, in_ready never 1.
- Result backpressure: out_ready=0 for 5 cycles -> result/out_valid held; start pulse during DONE ignored; second job (len=1, a=7, b=3) after release -> result=21.
- rstn asserted mid-RUN after 2 pairs -> all outputs 0 immediately, state IDLE; next job len=2 (5*5, 1*1) -> result=26 (no leftover P).
- Back-to-back jobs: len=3 ones×ones then len=2 (10*10, 2*2) -> results 3 then 104; first-tag opmode 0x01 clears prior P.
